// File: rtl/master_mem_copy_dma.sv
// Single-channel DMA engine for an on-chip word memory: copy (memmove-safe) or fill.
// Memory port signals are decoded combinationally from the current state and address pointers.
module master_mem_copy_dma #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 4087
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t            state_reg, state_next;
  logic              mode_reg, mode_next;
  logic              desc_reg, desc_next;
  logic              error_reg, error_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] words_done_reg, words_done_next;
  logic [DATA_W-1:0] fill_reg, fill_next;

  // One extra bit so end-of-range sums cannot wrap.
  logic [ADDR_W:0] src_end;
  logic [ADDR_W:0] dst_end;
  assign src_end = {1'b0, src_reg} + {1'b0, len_reg};
  assign dst_end = {1'b0, dst_reg} + {1'b0, len_reg};

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    desc_next       = desc_reg;
    error_next      = error_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    words_done_next = words_done_reg;
    fill_next       = fill_reg;
    busy            = (state_reg != S_IDLE);
    done            = 1'b0;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_writedata   = '0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          mode_next  = mode;
          src_next   = src_addr;
          dst_next   = dst_addr;
          len_next   = length;
          fill_next  = fill_data;
          error_next = 1'b0;
          state_next = S_CHECK;
        end
      end

      S_CHECK: begin
        if (len_reg == '0) begin
          state_next = S_DONE;
        end else if ((dst_end > MEM_LIMIT) || (!mode_reg && (src_end > MEM_LIMIT))) begin
          error_next = 1'b1;
          state_next = S_DONE;
        end else begin
          error_next      = 1'b0;
          words_done_next = '0;
          // Destination overlapping the tail of the source: walk backwards.
          desc_next = !mode_reg && (dst_reg > src_reg) && ({1'b0, dst_reg} < src_end);
          if (!mode_reg && (dst_reg > src_reg) && ({1'b0, dst_reg} < src_end)) begin
            src_next = src_reg + len_reg - ADDR_W'(1);
            dst_next = dst_reg + len_reg - ADDR_W'(1);
          end
          state_next = mode_reg ? S_WR : S_RD;
        end
      end

      S_RD: begin
        mem_chipselect = 1'b1;
        mem_address    = src_reg;
        if (abort) begin
          state_next = S_DONE;
        end else begin
          src_next   = desc_reg ? (src_reg - ADDR_W'(1)) : (src_reg + ADDR_W'(1));
          state_next = S_WR;
        end
      end

      S_WR: begin
        mem_chipselect  = 1'b1;
        mem_write       = 1'b1;
        mem_address     = dst_reg;
        mem_writedata   = mode_reg ? fill_reg : mem_readdata;
        words_done_next = words_done_reg + ADDR_W'(1);
        dst_next        = desc_reg ? (dst_reg - ADDR_W'(1)) : (dst_reg + ADDR_W'(1));
        if (abort || (words_done_reg + ADDR_W'(1) == len_reg)) begin
          state_next = S_DONE;
        end else begin
          state_next = mode_reg ? S_WR : S_RD;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      mode_reg       <= 1'b0;
      desc_reg       <= 1'b0;
      error_reg      <= 1'b0;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      words_done_reg <= '0;
      fill_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      desc_reg       <= desc_next;
      error_reg      <= error_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      words_done_reg <= words_done_next;
      fill_reg       <= fill_next;
    end
  end

  assign error          = error_reg;
  assign words_done     = words_done_reg;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

endmodule
